uart_mmio_fifo: RTL and testbench
=================================

# uart_mmio_fifo

Buffered memory-mapped UART port for the MIPS150 CPU. Sits directly downstream of the decode/control unit's UART strobes (WEUART, REUART, UARTsel) and upstream of the serial UART core. It decouples CPU stores and loads at 0x80000000–0x8000000c from the serial line with one TX FIFO and one RX FIFO, and produces the UART read-data word consumed by the writeback mux (RDsel = 2'b00).

## Interface
- DEPTH, 8: entries per FIFO; power of two, minimum 2.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- WEUART  in  1  store to 0x80000008; pushes DataIn[7:0] into TX FIFO.
- REUART  in  1  load from 0x8000000c; pops RX FIFO head at the clock edge.
- UARTsel  in  2  read source select: 00 RX data, 01 TX status, 10 RX status, 11 BIOS.
- DataIn  in  8  TX byte; low byte of store data.
- BIOSData  in  32  BIOS read word, passed through when UARTsel = 11.
- DataOut  out  32  read data to writeback mux.
- UA_TxData  out  8  byte to UART transmitter.
- UA_TxValid  out  1  TX byte available.
- UA_TxReady  in  1  transmitter accepts byte this cycle.
- UA_RxData  in  8  byte from UART receiver.
- UA_RxValid  in  1  receiver presents byte this cycle (single-cycle pulse, cannot stall).
- UA_RxReady  out  1  = ~reset.

## Operation
- Each FIFO: DEPTH×8 register array, rd/wr pointers of log2(DEPTH) bits that wrap modulo DEPTH, count of log2(DEPTH)+1 bits. Empty = (count == 0); full = (count == DEPTH).
- TX push: WEUART && !tx_full. WEUART while tx_full: byte dropped, pointers unchanged, tx_ovf set (sticky).
- TX pop: UA_TxValid && UA_TxReady. UA_TxValid = !tx_empty; UA_TxData = tx_mem[tx_rd].
- RX push: UA_RxValid && !rx_full. UA_RxValid while rx_full: byte dropped, rx_ovf set (sticky).
- RX pop: REUART && !rx_empty. REUART while rx_empty: no state change.
- Full/empty are evaluated on pre-edge count. A push when full is dropped even if a pop occurs on the same edge. A push and pop on a non-full, non-empty FIFO on the same edge leave count unchanged.
- Push and pop on an empty FIFO on the same edge: the pop is ignored, the push is accepted, and the count becomes 1.
- DataOut (combinational):
  - UARTsel 00: {24'b0, rx_mem[rx_rd]}. The value is stale/undefined when empty; software polls status first.
  - UARTsel 01: {30'b0, tx_ovf, !tx_full} (DataInReady).
  - UARTsel 10: {30'b0, rx_ovf, !rx_empty} (DataOutValid).
  - UARTsel 11: BIOSData.
- tx_ovf and rx_ovf clear only on reset.

## Timing
- Reset values: all pointers, counts, tx_ovf and rx_ovf = 0. UA_TxValid = 0, UA_RxReady = 0 during reset and 1 thereafter. DataOut = 0 for UARTsel 00/01/10 minus status bits: UARTsel 01 reads 1, UARTsel 10 reads 0.
- Reset asserted mid-transfer: pending FIFO contents are discarded at that edge, and UA_TxValid falls in the same cycle reset is sampled high.
- CPU store to TX: byte visible on UA_TxData/UA_TxValid in the cycle after the WEUART edge (1-cycle latency).
- Receiver to CPU: byte captured at the UA_RxValid edge. RX status reads 1 from the next cycle.
- REUART: DataOut shows the current head combinationally during the REUART cycle. The head advances at that edge, so back-to-back REUART cycles read consecutive bytes.
- Throughput: one push and one pop per FIFO per cycle.

## Test plan
- Reset, then UARTsel = 01 → DataOut = 32'h1. UARTsel = 10 → DataOut = 32'h0. UA_TxValid = 0.
- With UA_TxReady = 0, issue 9 WEUART pushes of bytes 0x41..0x49.
  - Expect UARTsel 01 = 32'h2 (full + tx_ovf).
  - Then raise UA_TxReady: UA_TxData sequence 0x41..0x48, with UA_TxValid low after 8 pops.
- Pulse UA_RxValid with 0x55, then 0xAA.
  - Expect UARTsel 10 = 32'h1.
  - Two consecutive REUART cycles with UARTsel 00 read 32'h55 then 32'hAA.
  - Status then reads 32'h0.
- Fill RX with 8 bytes, then send a 9th (0x99) → UARTsel 10 = 32'h3. The 9th byte never appears on reads, and the 8 reads return the first 8 bytes in order.
- Same-edge TX push and pop at count 3 → count stays 3 and order is preserved. REUART on empty RX → no pointer change, status stays 0.
- UARTsel 11 with BIOSData = 32'hDEADBEEF → DataOut = 32'hDEADBEEF. Assert reset with 4 bytes queued in TX → UA_TxValid = 0 next cycle, status 01 = 32'h1.

Source files
------------

// File: rtl/uart_mmio_fifo.sv
// Buffered memory-mapped UART port: a TX FIFO fed by CPU stores and an RX FIFO
// fed by the serial receiver, plus the read-data mux for the writeback stage.
module uart_mmio_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WEUART,
    input  logic        REUART,
    input  logic [1:0]  UARTsel,
    input  logic [7:0]  DataIn,
    input  logic [31:0] BIOSData,
    output logic [31:0] DataOut,
    output logic [7:0]  UA_TxData,
    output logic        UA_TxValid,
    input  logic        UA_TxReady,
    input  logic [7:0]  UA_RxData,
    input  logic        UA_RxValid,
    output logic        UA_RxReady
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_rd, tx_wr;
    logic [CW-1:0] tx_cnt;
    logic          tx_ovf;
    logic          tx_full, tx_empty, tx_push, tx_pop;

    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_rd, rx_wr;
    logic [CW-1:0] rx_cnt;
    logic          rx_ovf;
    logic          rx_full, rx_empty, rx_push, rx_pop;

    // Handshake decode; full/empty come from the pre-edge count, so a pop can
    // never make room for a push on the same edge, and a pop on empty is ignored.
    always_comb begin
        tx_full    = (tx_cnt == FullCnt);
        tx_empty   = (tx_cnt == '0);
        rx_full    = (rx_cnt == FullCnt);
        rx_empty   = (rx_cnt == '0);
        // Gated by reset so valid drops in the same cycle reset is sampled.
        UA_TxValid = !reset && !tx_empty;
        UA_TxData  = tx_mem[tx_rd];
        UA_RxReady = !reset;
        tx_push    = WEUART && !tx_full;
        tx_pop     = UA_TxValid && UA_TxReady;
        rx_push    = UA_RxValid && !rx_full;
        rx_pop     = REUART && !rx_empty;
    end

    // TX pointers, count and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_rd  <= '0;
            tx_wr  <= '0;
            tx_cnt <= '0;
            tx_ovf <= 1'b0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + AW'(1);
            if (tx_pop)  tx_rd <= tx_rd + AW'(1);
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + CW'(1);
            else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - CW'(1);
            if (WEUART && tx_full) tx_ovf <= 1'b1;
        end
    end

    // RX pointers, count and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_rd  <= '0;
            rx_wr  <= '0;
            rx_cnt <= '0;
            rx_ovf <= 1'b0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + AW'(1);
            if (rx_pop)  rx_rd <= rx_rd + AW'(1);
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + CW'(1);
            else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - CW'(1);
            if (UA_RxValid && rx_full) rx_ovf <= 1'b1;
        end
    end

    // Storage arrays; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (!reset && tx_push) tx_mem[tx_wr] <= DataIn;
        if (!reset && rx_push) rx_mem[rx_wr] <= UA_RxData;
    end

    // Read-data mux toward the writeback stage.
    always_comb begin
        DataOut = '0;
        unique case (UARTsel)
            2'b00: DataOut = {24'b0, rx_mem[rx_rd]};
            2'b01: DataOut = {30'b0, tx_ovf, !tx_full};
            2'b10: DataOut = {30'b0, rx_ovf, !rx_empty};
            2'b11: DataOut = BIOSData;
            default: DataOut = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed table-driven bench for uart_mmio_fifo.
module tb_uart_mmio_fifo;

    logic        clk;
    logic        reset;
    logic        WEUART, REUART;
    logic [1:0]  UARTsel;
    logic [7:0]  DataIn;
    logic [31:0] BIOSData;
    logic [31:0] DataOut;
    logic [7:0]  UA_TxData;
    logic        UA_TxValid, UA_TxReady;
    logic [7:0]  UA_RxData;
    logic        UA_RxValid, UA_RxReady;

    int n_chk  = 0;
    int n_fail = 0;

    uart_mmio_fifo #(.DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .WEUART    (WEUART),
        .REUART    (REUART),
        .UARTsel   (UARTsel),
        .DataIn    (DataIn),
        .BIOSData  (BIOSData),
        .DataOut   (DataOut),
        .UA_TxData (UA_TxData),
        .UA_TxValid(UA_TxValid),
        .UA_TxReady(UA_TxReady),
        .UA_RxData (UA_RxData),
        .UA_RxValid(UA_RxValid),
        .UA_RxReady(UA_RxReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, we, re, txr, rxv;
        logic [1:0]  sel;
        logic [7:0]  din, rxd;
        logic [31:0] bios;
        logic        cd;
        logic [31:0] ed;
        logic        etv;
        logic [7:0]  etd;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic we, input logic re,
                                input logic txr, input logic rxv, input logic [1:0] sel,
                                input logic [7:0] din, input logic [7:0] rxd,
                                input logic [31:0] bios, input logic cd,
                                input logic [31:0] ed, input logic etv,
                                input logic [7:0] etd, input string name);
        vec_t v;
        v.rst = rst; v.we = we; v.re = re; v.txr = txr; v.rxv = rxv; v.sel = sel;
        v.din = din; v.rxd = rxd; v.bios = bios; v.cd = cd; v.ed = ed;
        v.etv = etv; v.etd = etd; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic re, input logic txr,
                         input logic rxv, input logic [1:0] sel, input logic [7:0] din,
                         input logic [7:0] rxd, input logic [31:0] bios);
        @(negedge clk);
        reset = rst; WEUART = we; REUART = re; UA_TxReady = txr; UA_RxValid = rxv;
        UARTsel = sel; DataIn = din; UA_RxData = rxd; BIOSData = bios;
        #1;
    endtask

    initial begin
        reset = 1'b1; WEUART = 1'b0; REUART = 1'b0; UARTsel = 2'b01; DataIn = '0;
        BIOSData = '0; UA_TxReady = 1'b0; UA_RxData = '0; UA_RxValid = 1'b0;

        // Reset and idle status.
        add(1, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, "rst_txvalid");
        add(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 1, 32'h1, 0, 0, "rst_txstat");
        add(0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 1, 32'h0, 0, 0, "rst_rxstat");
        // Nine TX pushes with transmitter stalled; the ninth is dropped.
        for (int k = 0; k < 9; k++)
            add(0, 1, 0, 0, 0, 2'b01, 8'(8'h41 + k), 0, 0, 1, (k < 8) ? 32'h1 : 32'h0,
                k > 0, 8'h41, "tx_fill");
        add(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 1, 32'h2, 1, 8'h41, "tx_full_ovf");
        for (int i = 0; i < 8; i++)
            add(0, 0, 0, 1, 0, 2'b01, 0, 0, 0, 1, (i == 0) ? 32'h2 : 32'h3,
                1, 8'(8'h41 + i), "tx_drain");
        add(0, 0, 0, 1, 0, 2'b01, 0, 0, 0, 1, 32'h3, 0, 0, "tx_drained");
        // Two RX bytes read back-to-back.
        add(0, 0, 0, 0, 1, 2'b10, 0, 8'h55, 0, 1, 32'h0, 0, 0, "rx_push55");
        add(0, 0, 0, 0, 1, 2'b10, 0, 8'hAA, 0, 1, 32'h1, 0, 0, "rx_pushAA");
        add(0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 1, 32'h1, 0, 0, "rx_stat1");
        add(0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 1, 32'h55, 0, 0, "rx_read55");
        add(0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 1, 32'hAA, 0, 0, "rx_readAA");
        add(0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 1, 32'h0, 0, 0, "rx_stat0");
        add(0, 0, 1, 0, 0, 2'b10, 0, 0, 0, 1, 32'h0, 0, 0, "rx_pop_empty");
        add(0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 1, 32'h0, 0, 0, "rx_after_empty_pop");
        // RX overflow: 8 bytes then 0x99 dropped; pointers wrap on the reads.
        for (int i = 0; i < 8; i++)
            add(0, 0, 0, 0, 1, 2'b10, 0, 8'(8'h10 + i), 0, 1, (i == 0) ? 32'h0 : 32'h1,
                0, 0, "rx_fill");
        add(0, 0, 0, 0, 1, 2'b10, 0, 8'h99, 0, 1, 32'h1, 0, 0, "rx_push99");
        add(0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 1, 32'h3, 0, 0, "rx_full_ovf");
        for (int i = 0; i < 8; i++)
            add(0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 1, 32'(8'h10 + i), 0, 0, "rx_drain");
        add(0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 1, 32'h2, 0, 0, "rx_empty_ovf");
        // Same-edge TX push and pop at count 3.
        add(0, 1, 0, 0, 0, 2'b01, 8'h61, 0, 0, 1, 32'h3, 0, 0, "tx3_a");
        add(0, 1, 0, 0, 0, 2'b01, 8'h62, 0, 0, 1, 32'h3, 1, 8'h61, "tx3_b");
        add(0, 1, 0, 0, 0, 2'b01, 8'h63, 0, 0, 1, 32'h3, 1, 8'h61, "tx3_c");
        add(0, 1, 0, 1, 0, 2'b01, 8'h64, 0, 0, 1, 32'h3, 1, 8'h61, "tx3_pushpop");
        add(0, 0, 0, 1, 0, 2'b01, 0, 0, 0, 0, 0, 1, 8'h62, "tx3_pop62");
        add(0, 0, 0, 1, 0, 2'b01, 0, 0, 0, 0, 0, 1, 8'h63, "tx3_pop63");
        add(0, 0, 0, 1, 0, 2'b01, 0, 0, 0, 0, 0, 1, 8'h64, "tx3_pop64");
        add(0, 0, 0, 1, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, "tx3_empty");
        // BIOS passthrough.
        add(0, 0, 0, 0, 0, 2'b11, 0, 0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0, "bios");
        // Reset with 4 bytes queued in TX.
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, 0, 0, 2'b01, 8'(8'h71 + i), 0, 0, 0, 0, i > 0, 8'h71, "tx_q4");
        add(1, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, "rst_mid_txvalid");
        add(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 1, 32'h1, 0, 0, "rst_mid_txstat");
        add(0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 1, 32'h0, 0, 0, "rst_mid_rxstat");
        // Push and pop on an empty TX FIFO: push wins, count becomes 1.
        add(0, 1, 0, 1, 0, 2'b01, 8'h81, 0, 0, 0, 0, 0, 0, "tx_empty_pp");
        add(0, 0, 0, 1, 0, 2'b01, 0, 0, 0, 0, 0, 1, 8'h81, "tx_empty_pp_out");
        add(0, 0, 0, 1, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, "tx_empty_pp_done");

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].re, vecs[i].txr, vecs[i].rxv,
                  vecs[i].sel, vecs[i].din, vecs[i].rxd, vecs[i].bios);
            chk({vecs[i].name, "_txvalid"}, 32'(UA_TxValid), 32'(vecs[i].etv));
            if (vecs[i].etv)
                chk({vecs[i].name, "_txdata"}, 32'(UA_TxData), 32'(vecs[i].etd));
            if (vecs[i].cd)
                chk({vecs[i].name, "_dout"}, DataOut, vecs[i].ed);
            chk({vecs[i].name, "_rxready"}, 32'(UA_RxReady), 32'(!vecs[i].rst));
        end

        // RX full with simultaneous pop: the push is still dropped.
        for (int i = 0; i < 8; i++)
            drive(0, 0, 0, 0, 1, 2'b10, 0, 8'(8'hA0 + i), 0);
        drive(0, 0, 1, 0, 1, 2'b00, 0, 8'hEE, 0);
        chk("rxfull_pp_head", DataOut, 32'hA0);
        for (int i = 1; i < 8; i++) begin
            drive(0, 0, 1, 0, 0, 2'b00, 0, 0, 0);
            chk("rxfull_pp_drain", DataOut, 32'(8'hA0 + i));
        end
        drive(0, 0, 0, 0, 0, 2'b10, 0, 0, 0);
        chk("rxfull_pp_stat", DataOut, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
